// File: rtl/tx_arbiter.sv
// tx_arbiter
//   Round-robin scheduler sharing one 8-bit serial transmitter among N_REQ
//   byte sources. A source is granted, its byte is latched and launched with
//   a one-cycle tx_start, then the arbiter waits for the rising edge of
//   tx_done (or a watchdog timeout), holds an inter-frame gap and returns to
//   idle.
//
// Parameters
//   N_REQ       number of requesters (2..8)
//   GAP_CYCLES  idle cycles after each frame before the next grant (0 = none)
//   TIMEOUT     cycles allowed in WAIT_DONE before abort (>= 16)
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/_data   per-requester valid bit and byte (byte i at [8i+7:8i])
//   req_ready         one-hot accept, combinational
//   tx_start/tx_data  start pulse and byte to the transmitter (registered)
//   tx_busy/tx_done   transmitter status
//   grant_id          index of the frame in flight (registered)
//   active            high from accept through end of gap
//   frame_done        one-cycle pulse per completed frame
//   err_timeout       sticky watchdog-abort flag, cleared by err_clr
module tx_arbiter #(
    parameter int  N_REQ      = 4,
    parameter int  GAP_CYCLES = 2,
    parameter int  TIMEOUT    = 64,
    localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic [IDW-1:0]     grant_id,
    output logic               active,
    output logic               frame_done,
    output logic               err_timeout,
    input  logic               err_clr
);
    localparam int             WDW      = $clog2(TIMEOUT);
    localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;
    state_t state, state_nxt;

    logic [N_REQ-1:0][7:0] req_bytes;
    logic [IDW-1:0]        rr_ptr, sel_idx, ptr_nxt, cand;
    logic                  sel_found, accept, done_q, done_edge;
    logic                  wd_last, gap_last, timeout_hit;
    logic [WDW-1:0]        wd_cnt;
    logic [GW-1:0]         gap_cnt;

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_unpack
            assign req_bytes[g] = req_data[8*g +: 8];
        end
    endgenerate

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDW'(s);
    endfunction

    // First valid requester at or after rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = wrap_idx(rr_ptr, k);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // rst_n gates the accept so req_ready reads 0 while reset is held,
    // like every registered output.
    assign accept      = (state == IDLE) && sel_found && !tx_busy && rst_n;
    assign req_ready   = accept ? (N_REQ'(1) << sel_idx) : '0;
    assign ptr_nxt     = (sel_idx == IDW'(N_REQ - 1)) ? '0 : sel_idx + IDW'(1);

    // Only a fresh rising edge counts, so a done level left over from an
    // earlier frame cannot complete this one.
    assign done_edge   = tx_done & ~done_q;
    assign wd_last     = (wd_cnt == WD_LAST);
    assign gap_last    = (gap_cnt == GAP_LAST);
    assign timeout_hit = (state == WAIT_DONE) && wd_last && !done_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_DONE;
            WAIT_DONE: if (done_edge || wd_last) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:       if (gap_last) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            done_q      <= 1'b0;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            done_q     <= tx_done;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            // A timeout in the same cycle as err_clr keeps the flag set.
            if (timeout_hit)  err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_data  <= req_bytes[sel_idx];
                        grant_id <= sel_idx;
                        rr_ptr   <= ptr_nxt;
                        active   <= 1'b1;
                        tx_start <= 1'b1;
                    end
                end
                LAUNCH: wd_cnt <= '0;
                WAIT_DONE: begin
                    wd_cnt <= wd_cnt + WDW'(1);
                    if (done_edge) frame_done <= 1'b1;
                    if (done_edge || wd_last) begin
                        gap_cnt <= '0;
                        if (GAP_CYCLES == 0) active <= 1'b0;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (gap_last) active <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a timestamp-based model.
module tb_tx_arbiter;
    localparam int N   = 4;
    localparam int G   = 2;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic [1:0]     grant_id;
    logic           active, frame_done, err_timeout;
    logic           err_clr = 1'b0;

    tx_arbiter #(.N_REQ(N), .GAP_CYCLES(G), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id),
        .active(active), .frame_done(frame_done), .err_timeout(err_timeout),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- transmitter stand-in ----------------
    bit tx_auto = 1'b0, rand_tx = 1'b0, extra_busy = 1'b0;
    int lat = 5, dlen = 1;
    int t_start = -100, t_done_at = -100;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_auto) begin
            if (tx_start) begin
                if (rand_tx) begin
                    lat  = int'($urandom_range(1, 20));
                    dlen = int'($urandom_range(1, 3));
                end
                t_start   = cyc;
                t_done_at = cyc + lat;
            end
            tx_done = (cyc >= t_done_at) && (cyc < t_done_at + dlen);
            tx_busy = ((cyc >= t_start) && (cyc < t_done_at)) || extra_busy;
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is described by timestamps: accept cycle, wait-window start,
    // cycle the frame ended, cycle frame_done is due.
    int         m_ptr, m_acc, m_wst, m_end, m_fd, m_gid;
    bit         m_err, m_pd;
    logic [7:0] m_data;

    task automatic m_reset();
        m_ptr = 0; m_acc = -1; m_wst = 0; m_end = -1; m_fd = -1;
        m_gid = 0; m_err = 1'b0; m_pd = 1'b0; m_data = '0;
    endtask

    task automatic model_cycle();
        bit           idle, tmo;
        int           sel;
        logic [N-1:0] e_rdy;
        idle = (m_acc < 0) || (m_end >= 0 && cyc >= m_end + 1 + G);
        sel  = -1;
        if (idle && !tx_busy)
            for (int k = 0; k < N; k++)
                if (sel < 0 && req_valid[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
        e_rdy = (sel >= 0) ? (N'(1) << sel) : '0;

        chk("req_ready",   32'(req_ready),   32'(e_rdy));
        chk("tx_start",    32'(tx_start),    32'(m_acc >= 0 && cyc == m_acc + 1));
        chk("active",      32'(active),      32'(!idle));
        chk("frame_done",  32'(frame_done),  32'(cyc == m_fd));
        chk("err_timeout", 32'(err_timeout), 32'(m_err));
        chk("tx_data",     32'(tx_data),     32'(m_data));
        chk("grant_id",    32'(grant_id),    32'(m_gid));

        tmo = 1'b0;
        if (m_acc >= 0 && m_end < 0 && cyc >= m_wst) begin
            if (tx_done && !m_pd) begin
                m_end = cyc;
                m_fd  = cyc + 1;
            end else if (cyc == m_wst + TMO - 1) begin
                m_end = cyc;
                tmo   = 1'b1;
            end
        end
        if (tmo)          m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        if (sel >= 0) begin
            m_acc  = cyc;
            m_wst  = cyc + 2;
            m_end  = -1;
            m_data = req_data[8*sel +: 8];
            m_gid  = sel;
            m_ptr  = (sel + 1) % N;
        end
        m_pd = tx_done;
    endtask

    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) m_reset();
            else        model_cycle();
        end
    end

    // ---------------- helpers ----------------
    int gq[$];

    task automatic collect(input int n, input int budget);
        int b;
        b = 0;
        gq.delete();
        while (gq.size() < n && b < budget) begin
            tick();
            b++;
            if (tx_start) gq.push_back(int'(grant_id));
        end
        if (gq.size() < n) chk("collect_budget", 32'(gq.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = 0;
        while (active && b < budget) begin
            tick();
            b++;
        end
        if (active) chk("idle_budget", 32'(1), 32'(0));
    endtask

    function automatic int gq_at(input int i);
        return (gq.size() > i) ? gq[i] : -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},  32'(req_ready),   32'(0));
        chk({tag, "_start"},  32'(tx_start),    32'(0));
        chk({tag, "_data"},   32'(tx_data),     32'(0));
        chk({tag, "_gid"},    32'(grant_id),    32'(0));
        chk({tag, "_active"}, 32'(active),      32'(0));
        chk({tag, "_fd"},     32'(frame_done),  32'(0));
        chk({tag, "_err"},    32'(err_timeout), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit cyc=%0d", cyc);
        $fatal(1, "time limit");
    end

    // ---------------- scenarios ----------------
    initial begin
        int rr_exp[6];
        int fd_cnt, fd_at;
        bit found;
        rr_exp = '{0, 1, 2, 3, 0, 1};

        // Reset with every requester valid: outputs must all read 0.
        req_valid = 4'b1111;
        req_data  = 32'h13121110;
        tx_auto = 1'b1; lat = 10; dlen = 1;
        repeat (3) tick();
        @(negedge clk);
        chk_all_zero("rst");
        tick();
        #2 rst_n = 1'b1;

        // Round robin with all four held valid.
        collect(6, 300);
        req_valid = '0;
        for (int i = 0; i < 6; i++) chk("rr_order", 32'(gq_at(i)), 32'(rr_exp[i]));
        wait_idle(60);

        // Single byte from requester 2.
        tick();
        req_valid = 4'b0100;
        req_data[23:16] = 8'hA5;
        @(negedge clk);
        chk("sb_ready", 32'(req_ready), 32'(4'b0100));
        tick();
        @(negedge clk);
        chk("sb_start",      32'(tx_start),  32'(1));
        chk("sb_data",       32'(tx_data),   32'(8'hA5));
        chk("sb_gid",        32'(grant_id),  32'(2));
        chk("sb_ready_once", 32'(req_ready), 32'(0));
        tick();
        req_valid = '0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            @(negedge clk);
            if (frame_done) found = 1'b1;
        end
        chk("sb_fd_seen", 32'(found), 32'(1));
        tick();
        @(negedge clk);
        chk("sb_active_gap", 32'(active), 32'(1));
        tick();
        @(negedge clk);
        chk("sb_active_end", 32'(active), 32'(0));

        // Wrap and skip: pointer at 3, only 1 and 3 valid.
        tick();
        req_valid = 4'b1010;
        collect(2, 200);
        req_valid = '0;
        chk("wrap_first",  32'(gq_at(0)), 32'(3));
        chk("wrap_second", 32'(gq_at(1)), 32'(1));
        wait_idle(60);
        tick();
        req_valid = 4'b1111;
        collect(1, 50);
        req_valid = '0;
        chk("wrap_ptr_after", 32'(gq_at(0)), 32'(2));
        wait_idle(60);

        // Timeout with err_clr held through the wait window.
        tx_auto = 1'b0; tx_done = 1'b0; tx_busy = 1'b0;
        tick();
        req_valid = 4'b0001;
        collect(1, 20);
        req_valid = '0;
        for (int k = 0; k < TMO; k++) begin
            tick();
            err_clr = 1'b1;
            @(negedge clk);
            chk("to_err_low", 32'(err_timeout), 32'(0));
            chk("to_no_fd",   32'(frame_done),  32'(0));
        end
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("to_err_set", 32'(err_timeout), 32'(1));
        chk("to_no_fd",   32'(frame_done),  32'(0));
        tx_auto = 1'b1; lat = 4;
        wait_idle(20);
        tick();
        req_valid = 4'b0001;
        collect(1, 40);
        req_valid = '0;
        chk("to_regrant", 32'(gq_at(0)), 32'(0));
        wait_idle(60);
        @(negedge clk);
        chk("to_err_sticky", 32'(err_timeout), 32'(1));
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("to_err_clr", 32'(err_timeout), 32'(0));

        // Done stuck high before start, then one clean pulse.
        tx_auto = 1'b0;
        tick();
        tx_done = 1'b1;
        req_valid = 4'b0001;
        collect(1, 20);
        req_valid = '0;
        fd_cnt = 0;
        fd_at  = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            tx_done = (k <= 4) || (k == 7);
            @(negedge clk);
            if (frame_done) begin
                fd_cnt++;
                fd_at = k;
            end
        end
        chk("sh_fd_count", 32'(fd_cnt), 32'(1));
        chk("sh_fd_cycle", 32'(fd_at),  32'(8));
        wait_idle(20);

        // Busy blocks req_ready in IDLE.
        tick();
        tx_busy = 1'b1;
        req_valid = 4'b1111;
        repeat (4) begin
            @(negedge clk);
            chk("busy_block", 32'(req_ready), 32'(0));
            tick();
        end
        tx_busy = 1'b0;
        tx_auto = 1'b1; lat = 3;
        @(negedge clk);
        chk("busy_release", 32'(req_ready), 32'(4'b0010));
        tick();
        req_valid = '0;
        wait_idle(60);

        // Reset in the middle of WAIT_DONE.
        tx_auto = 1'b0; tx_done = 1'b0;
        tick();
        req_valid = 4'b0100;
        collect(1, 20);
        req_valid = 4'b1100;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("mr");
        tick();
        tick();
        #2 rst_n = 1'b1;
        tx_auto = 1'b1; lat = 5;
        collect(1, 10);
        req_valid = '0;
        chk("mr_first_grant", 32'(gq_at(0)), 32'(2));
        wait_idle(60);

        // Randomized traffic.
        rand_tx = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 3) == 0) req_valid = N'($urandom);
            if ($urandom_range(0, 7) == 0) req_data  = $urandom;
            err_clr    = ($urandom_range(0, 15) == 0);
            extra_busy = ($urandom_range(0, 9) == 0);
        end
        req_valid = '0; err_clr = 1'b0; extra_busy = 1'b0;
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin scheduler that shares one 8-bit serial transmitter among `N_REQ` byte sources. Each source offers one byte at a time over a valid/ready handshake. The arbiter picks the next source in rotation, loads its byte, pulses the transmitter's start, and waits for the done pulse. It then enforces an inter-frame gap and guards every frame with a timeout watchdog. It sits between the packet-producing logic and the serial transmitter and is that transmitter's only driver.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 2: idle cycles after each frame before the next grant; 0 = no gap.
- `TIMEOUT`, 64: cycles allowed between `tx_start` and `tx_done` before abort, ≥ 16.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: bit i = requester i has a byte.
- `req_data` in 8*N_REQ: byte i at [8i+7:8i].
- `req_ready` out N_REQ: one-hot accept; transfer when `req_valid[i] & req_ready[i]`.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_data` out 8: byte to the transmitter, registered.
- `tx_busy` in 1: transmitter busy.
- `tx_done` in 1: transmitter done; may be high for more than one cycle.
- `grant_id` out clog2(N_REQ): index of the frame in flight, registered.
- `active` out 1: high from accept through end of gap.
- `frame_done` out 1: one-cycle pulse per completed frame.
- `err_timeout` out 1: sticky, set on watchdog abort.
- `err_clr` in 1: synchronous clear of `err_timeout`.

## Operation
- Reset values:
  - All outputs are 0: `req_ready`, `tx_start`, `tx_data`, `grant_id`, `active`, `frame_done`, `err_timeout`.
  - `rr_ptr` = 0, state IDLE, internal counters 0, `done_q` = 0.
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE:
  - `req_ready` is combinational. It selects the first i with `req_valid[i]` = 1, searching from `rr_ptr` upward with wrap at N_REQ-1 → 0.
  - `req_ready` is forced to 0 when `tx_busy` = 1.
  - On transfer, register `tx_data` ← `req_data[i]`, `grant_id` ← i, `rr_ptr` ← (i+1) mod N_REQ, `active` ← 1, then go to LAUNCH.
  - With no valid requester, stay in IDLE and leave `rr_ptr` unchanged.
- LAUNCH:
  - Assert `tx_start` for exactly this cycle.
  - Clear the watchdog counter and go to WAIT_DONE.
- WAIT_DONE:
  - Done is detected on the rising edge only: `tx_done & ~done_q`. A level held high from a previous frame is ignored.
  - On a done edge, pulse `frame_done`, then go to GAP, or to IDLE if GAP_CYCLES = 0.
  - The watchdog counter increments each cycle.
  - When the counter reaches TIMEOUT-1 with no done edge, set `err_timeout`, give no `frame_done`, and go to GAP or IDLE exactly as on success.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE and clear `active`.
  - If GAP_CYCLES = 0, `active` clears on the WAIT_DONE exit edge.
- `tx_data` and `grant_id` hold from accept until the next accept.
- `err_clr` and a timeout in the same cycle: the set wins.
- Requesters may drop `req_valid` without a transfer. Only the one-hot `req_ready` bit completes a transfer.
- Asserting `rst_n` low mid-frame returns to the reset state immediately. A `tx_start` pulse in progress is cut.

## Timing
- Accept at edge N (end of the IDLE cycle):
  - `tx_start` is high in cycle N+1.
  - WAIT_DONE begins at N+2.
- A done edge sampled at edge M gives `frame_done` high in cycle M+1, and gap counting starts at M+1.
- Earliest next accept is M+1+GAP_CYCLES. With GAP_CYCLES = 0, `req_ready` may assert in cycle M+1.
- Minimum frame-to-frame `tx_start` spacing is transmitter latency + GAP_CYCLES + 3 cycles.
- `req_ready` is combinational from `req_valid`, state, `rr_ptr` and `tx_busy`. Every other output is registered.

## Test plan
- Single byte: requester 2 valid with 0xA5 and GAP_CYCLES = 2.
  - Required: `req_ready` = 4'b0100 for one cycle, then `tx_start` one cycle with `tx_data` = 0xA5 and `grant_id` = 2.
  - After `tx_done`: `frame_done` pulse, `active` low 2 cycles later.
- Round-robin: all four requesters held valid, `tx_done` modelled 10 cycles after start.
  - Required: grant order 0, 1, 2, 3, 0, 1.
  - No requester is granted twice before the others.
- Wrap and skip: `rr_ptr` = 3, only requesters 1 and 3 valid.
  - Required: grant 3, then 1, with `rr_ptr` = 2 afterwards.
- Timeout: start issued, `tx_done` held low, TIMEOUT = 16.
  - Required: `err_timeout` = 1 sixteen cycles after WAIT_DONE entry, no `frame_done`, arbiter resumes granting.
  - `err_clr` returns the flag to 0.
- Stuck-high done and busy blocking: `tx_done` high before `tx_start`, then one clean pulse.
  - Required: exactly one `frame_done`, for the clean pulse.
  - Separately, `tx_busy` = 1 in IDLE gives `req_ready` = 0.
- Mid-frame reset: `rst_n` pulled low in WAIT_DONE.
  - Required: all outputs 0 immediately and `rr_ptr` = 0.
  - After release, first grant goes to the lowest valid index.
